// File: rtl/tx_pkg.sv
// Shared transmit-path definitions: framer states, Barker sync word and payload mode encoding.
// The Barker constants are also used by the receive-side correlator.
package tx_pkg;

   localparam int unsigned BARKER_LEN = 13;
   localparam logic [BARKER_LEN-1:0] BARKER_13 = 13'b1111100110101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_BARKER,
      ST_PAYLOAD,
      ST_GUARD
   } tx_state_e;

   typedef enum logic {
      MODE_QPSK = 1'b0,
      MODE_BPSK = 1'b1
   } tx_mode_e;

endpackage

// File: rtl/packetizer_if.sv
// AXI-Stream-style byte channel feeding the packetizer.
interface packetizer_if;

   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/tx_byte_buffer.sv
// One-entry hold register for the payload byte stream; ready whenever the entry is empty.
module tx_byte_buffer (
   input  logic        clk_i,
   input  logic        rst_ni,
   packetizer_if.slave s_axis,
   input  logic        pop_i,
   output logic        full_o,
   output logic        last_o,
   output logic [7:0]  data_o
);

   logic       full_q, full_d;
   logic       last_q, last_d;
   logic [7:0] data_q, data_d;
   logic       accept;

   assign s_axis.tready = !full_q;
   assign accept        = s_axis.tvalid && !full_q;

   // A refill on the same edge as a pop wins, so the entry stays full.
   always_comb begin
      full_d = full_q;
      last_d = last_q;
      data_d = data_q;
      if (pop_i) begin
         full_d = 1'b0;
      end
      if (accept) begin
         full_d = 1'b1;
         last_d = s_axis.tlast;
         data_d = s_axis.tdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q <= 1'b0;
         last_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         last_q <= last_d;
         data_q <= data_d;
      end
   end

   assign full_o = full_q;
   assign last_o = last_q;
   assign data_o = data_q;

endmodule

// File: rtl/packetizer.sv
// Transmit framer: preamble, Barker sync, payload (BPSK bits or QPSK dibits), guard.
// Advances one symbol per clk_enable; symbol outputs are registered.
module packetizer #(
   parameter int unsigned           BARKER_LEN       = tx_pkg::BARKER_LEN,
   parameter logic [BARKER_LEN-1:0] BARKER_CODE      = tx_pkg::BARKER_13,
   parameter int unsigned           MAX_WINDOW_WIDTH = 8
) (
   input  logic                        clk_32M768,
   input  logic                        rst_n_32M768,
   input  logic                        clk_enable,
   input  logic [3:0]                  MODE_CTRL,
   input  logic [MAX_WINDOW_WIDTH-1:0] TX_PD_WINDOW,
   input  logic [MAX_WINDOW_WIDTH-1:0] TX_GUARD_WINDOW,
   packetizer_if.slave                 s_axis,
   output logic                        BPSK,
   output logic [1:0]                  QPSK,
   output logic                        is_bpsk,
   output logic                        sym_valid,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        underrun
);
   import tx_pkg::*;

   localparam int unsigned CW = (MAX_WINDOW_WIDTH > $clog2(BARKER_LEN)) ?
                                MAX_WINDOW_WIDTH : $clog2(BARKER_LEN);

   tx_state_e             state_q, state_d;
   tx_mode_e              mode_q, mode_d;
   logic [CW-1:0]         cnt_q, cnt_d, len_q, len_d, spb_m1;
   logic [7:0]            sh_q, sh_d;
   logic                  last_q, last_d;
   logic [BARKER_LEN-1:0] bk_q, bk_d;
   logic                  pop;
   logic                  hold_full, hold_last;
   logic [7:0]            hold_data;
   logic                  bpsk_q, bpsk_d, isb_q, isb_d, valid_q, valid_d;
   logic [1:0]            qpsk_q, qpsk_d;
   logic                  done_q, done_d, urun_q, urun_d;
   logic                  unused_mode_bits;

   assign unused_mode_bits = ^MODE_CTRL[3:1];

   tx_byte_buffer u_buf (
      .clk_i  (clk_32M768),
      .rst_ni (rst_n_32M768),
      .s_axis (s_axis),
      .pop_i  (pop),
      .full_o (hold_full),
      .last_o (hold_last),
      .data_o (hold_data)
   );

   assign spb_m1 = (mode_q == MODE_BPSK) ? CW'(7) : CW'(3);

   always_comb begin : next_state
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      sh_d    = sh_q;
      last_d  = last_q;
      bk_d    = bk_q;
      pop     = 1'b0;
      done_d  = 1'b0;
      urun_d  = 1'b0;
      if (clk_enable) begin
         unique case (state_q)
            ST_IDLE: if (hold_full) begin
               state_d = ST_PREAMBLE;
               cnt_d   = '0;
               mode_d  = tx_mode_e'(MODE_CTRL[0]);
               len_d   = (TX_PD_WINDOW == '0) ? CW'(1) : CW'(TX_PD_WINDOW);
            end
            ST_PREAMBLE: if (cnt_q < len_q - CW'(1)) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               state_d = ST_BARKER;
               cnt_d   = '0;
               bk_d    = BARKER_CODE;
            end
            ST_BARKER: if (cnt_q < CW'(BARKER_LEN - 1)) begin
               cnt_d = cnt_q + CW'(1);
               bk_d  = bk_q << 1;
            end else begin
               state_d = ST_PAYLOAD;
               cnt_d   = '0;
               sh_d    = hold_data;
               last_d  = hold_last;
               pop     = 1'b1;
            end
            ST_PAYLOAD: if (cnt_q < spb_m1) begin
               cnt_d = cnt_q + CW'(1);
               sh_d  = (mode_q == MODE_BPSK) ? {sh_q[6:0], 1'b0} : {sh_q[5:0], 2'b00};
            end else if (!last_q && hold_full) begin
               cnt_d  = '0;
               sh_d   = hold_data;
               last_d = hold_last;
               pop    = 1'b1;
            end else begin
               // A zero-length guard leaves straight to IDLE so no guard symbol is spent.
               urun_d = !last_q;
               cnt_d  = '0;
               if (TX_GUARD_WINDOW == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_GUARD;
                  len_d   = CW'(TX_GUARD_WINDOW);
               end
            end
            ST_GUARD: if (cnt_q < len_q - CW'(1)) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Symbol mapper works on the state being entered, so the register shows it after the edge.
   always_comb begin : mapper
      bpsk_d  = 1'b0;
      qpsk_d  = '0;
      isb_d   = 1'b1;
      valid_d = 1'b0;
      case (state_d)
         ST_PREAMBLE: begin
            valid_d = 1'b1;
            bpsk_d  = ~cnt_d[0];
            qpsk_d  = {2{~cnt_d[0]}};
         end
         ST_BARKER: begin
            valid_d = 1'b1;
            bpsk_d  = bk_d[BARKER_LEN-1];
            qpsk_d  = {2{bk_d[BARKER_LEN-1]}};
         end
         ST_PAYLOAD: begin
            valid_d = 1'b1;
            isb_d   = (mode_d == MODE_BPSK);
            bpsk_d  = sh_d[7];
            qpsk_d  = (mode_d == MODE_BPSK) ? {2{sh_d[7]}} : sh_d[7:6];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
      if (!rst_n_32M768) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_BPSK;
         cnt_q   <= '0;
         len_q   <= '0;
         sh_q    <= '0;
         last_q  <= 1'b0;
         bk_q    <= '0;
         bpsk_q  <= 1'b0;
         qpsk_q  <= '0;
         isb_q   <= 1'b1;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         urun_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         sh_q    <= sh_d;
         last_q  <= last_d;
         bk_q    <= bk_d;
         done_q  <= done_d;
         urun_q  <= urun_d;
         if (clk_enable) begin
            bpsk_q  <= bpsk_d;
            qpsk_q  <= qpsk_d;
            isb_q   <= isb_d;
            valid_q <= valid_d;
         end
      end
   end

   assign BPSK       = bpsk_q;
   assign QPSK       = qpsk_q;
   assign is_bpsk    = isb_q;
   assign sym_valid  = valid_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = done_q;
   assign underrun   = urun_q;

endmodule

// File: tb/tb_packetizer.sv
// Self-checking bench for packetizer: per-enable symbol stream compared against a frame-level model.
module tb_packetizer;

   localparam int unsigned W   = 8;
   localparam int unsigned GAP = 2;

   typedef struct packed {
      logic       valid;
      logic       isb;
      logic       b;
      logic [1:0] q;
      logic       busy;
      logic       done;
      logic       ur;
   } sym_t;

   typedef struct {
      int          pd;
      int          gd;
      logic [3:0]  mc;
      int          nb;
      logic [63:0] data;
      int          exp_v;
      int          exp_b;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           clk_enable = 1'b0;
   logic [3:0]     MODE_CTRL = '0;
   logic [W-1:0]   TX_PD_WINDOW = '0;
   logic [W-1:0]   TX_GUARD_WINDOW = '0;
   logic           BPSK;
   logic [1:0]     QPSK;
   logic           is_bpsk, sym_valid, busy, frame_done, underrun;

   packetizer_if bus ();

   packetizer #(
      .BARKER_LEN       (13),
      .BARKER_CODE      (13'b1111100110101),
      .MAX_WINDOW_WIDTH (W)
   ) dut (
      .clk_32M768      (clk),
      .rst_n_32M768    (rst_n),
      .clk_enable      (clk_enable),
      .MODE_CTRL       (MODE_CTRL),
      .TX_PD_WINDOW    (TX_PD_WINDOW),
      .TX_GUARD_WINDOW (TX_GUARD_WINDOW),
      .s_axis          (bus),
      .BPSK            (BPSK),
      .QPSK            (QPSK),
      .is_bpsk         (is_bpsk),
      .sym_valid       (sym_valid),
      .busy            (busy),
      .frame_done      (frame_done),
      .underrun        (underrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_done = 0;
   int exp_ur = 0;
   int done_clks = 0;
   int ur_clks = 0;
   int accepted = 0;
   int stall_clks = 0;
   logic [8:0] src_q[$];
   logic rdy_s = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Byte source: presents the queue head, retires it once a handshake has happened.
   initial begin
      bus.tvalid = 1'b0;
      bus.tdata  = '0;
      bus.tlast  = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tvalid && rdy_s) begin
            void'(src_q.pop_front());
            accepted++;
         end
         if (bus.tvalid && !rdy_s) stall_clks++;
         if (src_q.size() > 0) begin
            bus.tvalid = 1'b1;
            {bus.tlast, bus.tdata} = src_q[0];
         end else begin
            bus.tvalid = 1'b0;
            bus.tlast  = 1'b0;
            bus.tdata  = '0;
         end
         rdy_s = bus.tready;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (frame_done === 1'b1) done_clks++;
         if (underrun === 1'b1) ur_clks++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(output sym_t o);
      @(negedge clk);
      clk_enable = 1'b1;
      @(negedge clk);
      clk_enable = 1'b0;
      o = {sym_valid, is_bpsk, BPSK, QPSK, busy, frame_done, underrun};
      repeat (GAP) @(negedge clk);
   endtask

   function automatic sym_t mk(input logic v, input logic i, input logic b, input logic [1:0] q,
                               input logic bz, input logic d, input logic u);
      sym_t s;
      s = {v, i, b, q, bz, d, u};
      return s;
   endfunction

   task automatic run_frame(input string tag, input int pd, input int gd, input logic [3:0] mc,
                            input int nb, input logic [63:0] data, input bit tag_last,
                            input bit perturb, output int vcnt, output int bcnt);
      sym_t        exp_q[$];
      bit          care_q[$];
      sym_t        got, e;
      logic [12:0] code;
      logic [7:0]  byt;
      logic [1:0]  d;
      logic        b;
      int          n_pre, after_pay, acc0;
      code  = 13'b1111100110101;
      n_pre = (pd == 0) ? 1 : pd;
      for (int i = 0; i < n_pre; i++) begin
         b = (i % 2 == 0);
         exp_q.push_back(mk(1'b1, 1'b1, b, {b, b}, 1'b1, 1'b0, 1'b0));
         care_q.push_back(1'b1);
      end
      for (int i = 0; i < 13; i++) begin
         b = code[12-i];
         exp_q.push_back(mk(1'b1, 1'b1, b, {b, b}, 1'b1, 1'b0, 1'b0));
         care_q.push_back(1'b1);
      end
      for (int j = 0; j < nb; j++) begin
         byt = data[63-8*j -: 8];
         if (mc[0]) begin
            for (int k = 7; k >= 0; k--) begin
               b = byt[k];
               exp_q.push_back(mk(1'b1, 1'b1, b, {b, b}, 1'b1, 1'b0, 1'b0));
               care_q.push_back(1'b1);
            end
         end else begin
            for (int k = 3; k >= 0; k--) begin
               d = byt[2*k +: 2];
               exp_q.push_back(mk(1'b1, 1'b0, d[1], d, 1'b1, 1'b0, 1'b0));
               care_q.push_back(1'b1);
            end
         end
      end
      after_pay = exp_q.size();
      for (int g = 0; g < gd; g++) begin
         exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
         care_q.push_back(1'b0);
      end
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
      care_q.push_back(1'b1);
      if (!tag_last) begin
         exp_q[after_pay].ur = 1'b1;
         exp_ur++;
      end
      exp_done++;

      MODE_CTRL       = mc;
      TX_PD_WINDOW    = W'(pd);
      TX_GUARD_WINDOW = W'(gd);
      acc0 = accepted;
      for (int j = 0; j < nb; j++) begin
         src_q.push_back({(tag_last && (j == nb - 1)), data[63-8*j -: 8]});
      end
      repeat (3) @(negedge clk);
      vcnt = 0;
      bcnt = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
         step(got);
         if (perturb && k == 1) begin
            MODE_CTRL    = 4'($urandom);
            TX_PD_WINDOW = W'($urandom);
         end
         e = exp_q[k];
         if (!care_q[k]) begin
            e.isb   = 1'b0;
            got.isb = 1'b0;
         end
         if (got.valid) vcnt++;
         if (got.busy) bcnt++;
         check($sformatf("%s sym%0d {v,isb,b,q,busy,done,ur}", tag, k), 32'(got), 32'(e));
      end
      check({tag, " bytes accepted"}, accepted - acc0, nb);
   endtask

   initial begin
      vec_t vt[6];
      sym_t got;
      int   v, bz, st0, pd, gd, nb;
      logic [3:0] mc;

      vt[0] = '{4,   2,   4'b0001, 2, 64'hA53C_0000_0000_0000, 33,  35};
      vt[1] = '{4,   2,   4'b0000, 1, 64'hB400_0000_0000_0000, 21,  23};
      vt[2] = '{0,   0,   4'b1001, 1, 64'h8100_0000_0000_0000, 22,  22};
      vt[3] = '{1,   1,   4'b1110, 3, 64'h5AC3_0F00_0000_0000, 26,  27};
      vt[4] = '{255, 255, 4'b0000, 2, 64'hE71B_0000_0000_0000, 276, 531};
      vt[5] = '{3,   0,   4'b0001, 3, 64'h1234_5600_0000_0000, 40,  40};

      #1 rst_n = 1'b0;
      #1;
      check("reset {BPSK,QPSK,isb,valid,busy,done,ur,tready}",
            {BPSK, QPSK, is_bpsk, sym_valid, busy, frame_done, underrun, bus.tready}, 8'b0_00_1_0_0_0_0_1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int t = 0; t < 6; t++) begin
         st0 = stall_clks;
         run_frame($sformatf("vec%0d", t), vt[t].pd, vt[t].gd, vt[t].mc, vt[t].nb, vt[t].data,
                   1'b1, 1'b0, v, bz);
         check($sformatf("vec%0d sym_valid enables", t), v, vt[t].exp_v);
         check($sformatf("vec%0d busy enables", t), bz, vt[t].exp_b);
         if (vt[t].nb == 3) check($sformatf("vec%0d tready stalled", t), 32'(stall_clks > st0), 1);
      end

      run_frame("underrun", 2, 3, 4'b0001, 1, 64'h6E00_0000_0000_0000, 1'b0, 1'b0, v, bz);
      check("underrun sym_valid enables", v, 23);
      check("underrun busy enables", bz, 26);

      MODE_CTRL       = 4'b0001;
      TX_PD_WINDOW    = W'(4);
      TX_GUARD_WINDOW = W'(2);
      src_q.push_back({1'b1, 8'hC3});
      repeat (3) @(negedge clk);
      for (int k = 0; k < 20; k++) step(got);
      check("pre-reset {valid,busy}", {got.valid, got.busy}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      check("mid-frame reset {BPSK,QPSK,isb,valid,busy,done,ur,tready}",
            {BPSK, QPSK, is_bpsk, sym_valid, busy, frame_done, underrun, bus.tready}, 8'b0_00_1_0_0_0_0_1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_frame("post-reset", 3, 1, 4'b0000, 1, 64'h2D00_0000_0000_0000, 1'b1, 1'b0, v, bz);
      check("post-reset sym_valid enables", v, 3 + 13 + 4);

      for (int r = 0; r < 6; r++) begin
         pd = $urandom_range(0, 10);
         gd = $urandom_range(0, 4);
         mc = 4'($urandom);
         nb = $urandom_range(1, 5);
         run_frame($sformatf("rand%0d", r), pd, gd, mc, nb, {$urandom, $urandom}, 1'b1, 1'b1, v, bz);
         check($sformatf("rand%0d sym_valid enables", r), v,
               ((pd == 0) ? 1 : pd) + 13 + nb * (mc[0] ? 8 : 4));
      end

      repeat (4) @(negedge clk);
      check("frame_done pulse clocks", done_clks, exp_done);
      check("underrun pulse clocks", ur_clks, exp_ur);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
